// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: 2-bit counter
// encodings, indexing-mode selectors and the saturating counter step.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,   // strong not-taken
      WNT = 2'b01,   // weak not-taken
      WT  = 2'b10,   // weak taken
      ST  = 2'b11    // strong taken
   } ctr_t;

   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE  = 1;

   // One step toward the resolved outcome, pinned at SNT/ST.
   function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
      ctr_t n;
      n = c;
      if (taken) begin
         if (c != ST) n = ctr_t'(c + 2'b01);
      end else begin
         if (c != SNT) n = ctr_t'(c - 2'b01);
      end
      return n;
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port for
// fetch lookup, one synchronous write port for resolved taken branches.
module bp_btb
   import bp_pkg::*;
#(
   parameter int PC_W      = 8,
   parameter int BTB_IDX_W = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PC_W-1:0] rd_pc,
   output logic            rd_hit,
   output logic [PC_W-1:0] rd_target,
   input  logic            we,
   input  logic [PC_W-1:0] wr_pc,
   input  logic [PC_W-1:0] wr_target
);

   localparam int TAG_W = PC_W - BTB_IDX_W;
   localparam int N     = 1 << BTB_IDX_W;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
   } entry_t;

   entry_t tbl [N];
   entry_t rd_e;

   // Lookup: a miss reports a zero target so downstream never sees stale data.
   always_comb begin
      rd_e      = tbl[rd_pc[BTB_IDX_W-1:0]];
      rd_hit    = rd_e.valid && (rd_e.tag == rd_pc[PC_W-1:BTB_IDX_W]);
      rd_target = rd_hit ? rd_e.target : '0;
   end

   // Write replaces whatever lived at the index (no associativity).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) tbl[i] <= '0;
      end else if (we) begin
         tbl[wr_pc[BTB_IDX_W-1:0]] <= '{valid: 1'b1,
                                        tag: wr_pc[PC_W-1:BTB_IDX_W],
                                        target: wr_target};
      end
   end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal direction predictor with a direct-mapped BTB, a
// non-speculative global history register and saturating perf counters.
module branch_predictor_gshare
   import bp_pkg::*;
#(
   parameter int PC_W      = 8,
   parameter int PHT_IDX_W = 4,
   parameter int GHR_W     = 4,
   parameter int BTB_IDX_W = 3,
   parameter int MODE      = 1,
   parameter int PERF_W    = 16,
   // Physical GHR width; a zero-width history still needs a 1-bit port.
   localparam int GW       = (GHR_W > 0) ? GHR_W : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [PC_W-1:0]   lookup_pc,
   output logic              predict_taken,
   output logic [PC_W-1:0]   predict_target,
   output logic              btb_hit,
   output logic [GW-1:0]     ghr_snapshot,
   input  logic              update_valid,
   input  logic [PC_W-1:0]   update_pc,
   input  logic [GW-1:0]     update_ghr,
   input  logic              update_taken,
   input  logic [PC_W-1:0]   update_target,
   input  logic              update_mispredict,
   output logic [PERF_W-1:0] perf_branches,
   output logic [PERF_W-1:0] perf_mispredicts
);

   localparam int PHT_N = 1 << PHT_IDX_W;

   ctr_t                 pht [PHT_N];
   logic [GW-1:0]        ghr;
   logic [PHT_IDX_W-1:0] hist_lk, hist_up, lk_idx, up_idx;
   ctr_t                 lk_ctr;
   logic                 upd_fire;

   assign upd_fire = enable & update_valid;

   // History register: shifts in resolved outcomes only (non-speculative).
   generate
      if (GHR_W > 0) begin : g_ghr
         always_ff @(posedge clk or posedge rst) begin
            if (rst)           ghr <= '0;
            else if (upd_fire) ghr <= GW'({ghr, update_taken});
         end
         assign hist_lk = (MODE == MODE_GSHARE) ? PHT_IDX_W'(ghr)        : '0;
         assign hist_up = (MODE == MODE_GSHARE) ? PHT_IDX_W'(update_ghr) : '0;
      end else begin : g_no_ghr
         assign ghr     = '0;
         assign hist_lk = '0;
         assign hist_up = '0;
      end
   endgenerate

   assign ghr_snapshot = ghr;

   // Lookup hashes with live history; update hashes with the snapshot
   // the branch carried down the pipe, so both land on the same counter.
   assign lk_idx = lookup_pc[PHT_IDX_W-1:0] ^ hist_lk;
   assign up_idx = update_pc[PHT_IDX_W-1:0] ^ hist_up;

   // Direction read: gated by BTB hit since a target is needed to redirect.
   always_comb begin
      lk_ctr        = pht[lk_idx];
      predict_taken = btb_hit & lk_ctr[1];
   end

   // Pattern table: train the indexed counter on each resolved branch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PHT_N; i++) pht[i] <= WNT;
      end else if (upd_fire) begin
         pht[up_idx] <= ctr_next(pht[up_idx], update_taken);
      end
   end

   bp_btb #(
      .PC_W      (PC_W),
      .BTB_IDX_W (BTB_IDX_W)
   ) u_btb (
      .clk       (clk),
      .rst       (rst),
      .rd_pc     (lookup_pc),
      .rd_hit    (btb_hit),
      .rd_target (predict_target),
      .we        (upd_fire & update_taken),
      .wr_pc     (update_pc),
      .wr_target (update_target)
   );

   // Perf counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else if (upd_fire) begin
         if (perf_branches != '1)
            perf_branches <= perf_branches + 1'b1;
         if (update_mispredict && (perf_mispredicts != '1))
            perf_mispredicts <= perf_mispredicts + 1'b1;
      end
   end

endmodule
